nanosoc_expram_init_ctrl: RTL and testbench

NANOSOC_EXPRAM_INIT_CTRL -- requirements
Module: nanosoc_expram_init_ctrl

---
 rtl/nanosoc_expram_pkg.sv | 25 ++
 rtl/nanosoc_ahb_addr_hold.sv | 68 ++++++
 rtl/nanosoc_expram_init_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_nanosoc_expram_init_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanosoc_expram_pkg.sv
// Shared types and AHB constants for the expansion RAM zero-fill controller.
// Used by the controller top and its pending address-phase holder.
package nanosoc_expram_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPLAY = 2'd2,
        ST_PASS   = 2'd3
    } init_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_INIT    = 4'b0011;

    function automatic logic ahb_addr_phase(
        input logic       sel,
        input logic [1:0] trans,
        input logic       ready
    );
        return sel & trans[1] & ready;
    endfunction

endpackage

// File: rtl/nanosoc_ahb_addr_hold.sv
// Single-entry holding register for one stalled AHB address phase.
// Clear takes priority over capture.
module nanosoc_ahb_addr_hold
    import nanosoc_expram_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic [2:0]        hsize_i,
    input  logic [3:0]        hprot_i,
    input  logic              hwrite_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] haddr_o,
    output logic [2:0]        hsize_o,
    output logic [3:0]        hprot_o,
    output logic              hwrite_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [3:0]        prot_q, prot_d;
    logic              write_q, write_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        size_d  = size_q;
        prot_d  = prot_q;
        write_d = write_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            addr_d  = haddr_i;
            size_d  = hsize_i;
            prot_d  = hprot_i;
            write_d = hwrite_i;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= HSIZE_WORD;
            prot_q  <= '0;
            write_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            prot_q  <= prot_d;
            write_q <= write_d;
        end
    end

    assign valid_o  = valid_q;
    assign haddr_o  = addr_q;
    assign hsize_o  = size_q;
    assign hprot_o  = prot_q;
    assign hwrite_o = write_q;

endmodule

// File: rtl/nanosoc_expram_init_ctrl.sv
// Zero-fills the expansion SRAM after reset or on request, holding off one
// upstream AHB transfer until the fill completes, then passes through.
module nanosoc_expram_init_ctrl
    import nanosoc_expram_pkg::*;
#(
    parameter int SYS_ADDR_W          = 32,
    parameter int SYS_DATA_W          = 32,
    parameter int EXPRAM_L_RAM_ADDR_W = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic                  HSEL,
    input  logic [SYS_ADDR_W-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [SYS_DATA_W-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [SYS_DATA_W-1:0] HRDATA,

    output logic                  MHSEL,
    output logic [SYS_ADDR_W-1:0] MHADDR,
    output logic [1:0]            MHTRANS,
    output logic [2:0]            MHSIZE,
    output logic [3:0]            MHPROT,
    output logic                  MHWRITE,
    output logic                  MHREADY,
    output logic [SYS_DATA_W-1:0] MHWDATA,
    input  logic                  MHREADYOUT,
    input  logic                  MHRESP,
    input  logic [SYS_DATA_W-1:0] MHRDATA,

    input  logic                  INIT_REQ,
    output logic                  INIT_DONE
);

    localparam int CNT_W = EXPRAM_L_RAM_ADDR_W - 2;
    localparam int PAD_W = SYS_ADDR_W - EXPRAM_L_RAM_ADDR_W;

    init_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             done_q, done_d;

    logic                  pend_v;
    logic [SYS_ADDR_W-1:0] pend_addr;
    logic [2:0]            pend_size;
    logic [3:0]            pend_prot;
    logic                  pend_write;

    logic                  addr_ph;
    logic                  in_fill;
    logic                  reinit;
    logic                  capture;
    logic                  clear;
    logic [SYS_ADDR_W-1:0] fill_addr;

    assign addr_ph   = ahb_addr_phase(HSEL, HTRANS, HREADY);
    assign in_fill   = (state_q == ST_INIT) || (state_q == ST_DRAIN);
    assign reinit    = (state_q == ST_PASS) && req_q && HREADY;
    assign capture   = addr_ph && !pend_v && (in_fill || reinit);
    assign clear     = (state_q == ST_REPLAY);
    assign fill_addr = {{PAD_W{1'b0}}, cnt_q, 2'b00};

    nanosoc_ahb_addr_hold #(
        .ADDR_W (SYS_ADDR_W)
    ) u_hold (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .capture_i (capture),
        .clear_i   (clear),
        .haddr_i   (HADDR),
        .hsize_i   (HSIZE),
        .hprot_i   (HPROT),
        .hwrite_i  (HWRITE),
        .valid_o   (pend_v),
        .haddr_o   (pend_addr),
        .hsize_o   (pend_size),
        .hprot_o   (pend_prot),
        .hwrite_o  (pend_write)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        done_d  = done_q;
        if (state_q == ST_PASS && INIT_REQ) begin
            req_d = 1'b1;
        end
        unique case (state_q)
            ST_INIT: begin
                // The last word moves on without wrapping the counter
                if (MHREADYOUT) begin
                    if (&cnt_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (MHREADYOUT) begin
                    state_d = (pend_v || capture) ? ST_REPLAY : ST_PASS;
                    done_d  = 1'b1;
                end
            end
            ST_REPLAY: begin
                state_d = ST_PASS;
            end
            ST_PASS: begin
                if (reinit) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        MHSEL     = HSEL;
        MHADDR    = HADDR;
        MHTRANS   = HTRANS;
        MHSIZE    = HSIZE;
        MHPROT    = HPROT;
        MHWRITE   = HWRITE;
        MHREADY   = HREADY;
        MHWDATA   = HWDATA;
        HREADYOUT = MHREADYOUT;
        HRESP     = MHRESP;
        HRDATA    = MHRDATA;
        unique case (state_q)
            ST_INIT: begin
                MHSEL     = 1'b1;
                MHADDR    = fill_addr;
                MHTRANS   = HTRANS_NONSEQ;
                MHSIZE    = HSIZE_WORD;
                MHPROT    = HPROT_INIT;
                MHWRITE   = 1'b1;
                MHREADY   = MHREADYOUT;
                MHWDATA   = '0;
                HREADYOUT = !pend_v;
                HRESP     = 1'b0;
                HRDATA    = '0;
            end
            ST_DRAIN: begin
                MHSEL     = 1'b0;
                MHADDR    = '0;
                MHTRANS   = HTRANS_IDLE;
                MHSIZE    = HSIZE_WORD;
                MHPROT    = HPROT_INIT;
                MHWRITE   = 1'b0;
                MHREADY   = MHREADYOUT;
                MHWDATA   = '0;
                HREADYOUT = !pend_v;
                HRESP     = 1'b0;
                HRDATA    = '0;
            end
            ST_REPLAY: begin
                MHSEL     = 1'b1;
                MHADDR    = pend_addr;
                MHTRANS   = HTRANS_NONSEQ;
                MHSIZE    = pend_size;
                MHPROT    = pend_prot;
                MHWRITE   = pend_write;
                MHREADY   = 1'b1;
                MHWDATA   = '0;
                HREADYOUT = 1'b0;
                HRESP     = 1'b0;
                HRDATA    = '0;
            end
            ST_PASS: begin
                // An address phase seen while leaving for a refill is held
                if (reinit) begin
                    MHSEL   = 1'b0;
                    MHTRANS = HTRANS_IDLE;
                end
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    assign INIT_DONE = done_q;

endmodule

// File: tb/tb_nanosoc_expram_init_ctrl.sv
// Bench for nanosoc_expram_init_ctrl: AHB manager driver, wait-state SRAM
// model, queues of expected fill addresses and upstream read data.
`timescale 1ns/1ps
module tb_nanosoc_expram_init_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        MHSEL;
    logic [31:0] MHADDR;
    logic [1:0]  MHTRANS;
    logic [2:0]  MHSIZE;
    logic [3:0]  MHPROT;
    logic        MHWRITE;
    logic        MHREADY;
    logic [31:0] MHWDATA;
    logic        MHREADYOUT;
    logic        MHRESP;
    logic [31:0] MHRDATA;
    logic        INIT_REQ;
    logic        INIT_DONE;

    int n_chk = 0;
    int n_err = 0;

    logic [11:0] fill_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] mem [0:4095];
    logic        dp_v;
    logic        dp_w;
    logic [11:0] dp_a;
    logic [1:0]  wcnt;
    logic        wait_en;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    nanosoc_expram_init_ctrl dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HPROT      (HPROT),
        .HWRITE     (HWRITE),
        .HREADY     (HREADY),
        .HWDATA     (HWDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .MHSEL      (MHSEL),
        .MHADDR     (MHADDR),
        .MHTRANS    (MHTRANS),
        .MHSIZE     (MHSIZE),
        .MHPROT     (MHPROT),
        .MHWRITE    (MHWRITE),
        .MHREADY    (MHREADY),
        .MHWDATA    (MHWDATA),
        .MHREADYOUT (MHREADYOUT),
        .MHRESP     (MHRESP),
        .MHRDATA    (MHRDATA),
        .INIT_REQ   (INIT_REQ),
        .INIT_DONE  (INIT_DONE)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic fill_mon(input logic [11:0] wa, input logic [31:0] wd);
        logic [11:0] e;
        if (fill_q.size() == 0) begin
            chk("fill_extra", {20'd0, wa}, 32'hFFFF_FFFF);
        end else begin
            e = fill_q.pop_front();
            chk("fill_addr", {20'd0, wa}, {20'd0, e});
            chk("fill_data", wd, 32'h0);
        end
    endtask

    // SRAM model: garbage after reset, random wait states when enabled
    assign MHREADYOUT = !(dp_v && wcnt != 2'd0);
    assign MHRDATA    = (dp_v && !dp_w) ? mem[dp_a] : 32'h0;
    assign MHRESP     = 1'b0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_v <= 1'b0;
            dp_w <= 1'b0;
            dp_a <= 12'd0;
            wcnt <= 2'd0;
            for (int i = 0; i < 4096; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
        end else if (dp_v && wcnt != 2'd0) begin
            wcnt <= wcnt - 2'd1;
        end else begin
            if (dp_v && dp_w) begin
                mem[dp_a] <= MHWDATA;
                if (!INIT_DONE) fill_mon(dp_a, MHWDATA);
            end
            if (MHSEL && MHTRANS[1] && MHREADY) begin
                dp_v <= 1'b1;
                dp_w <= MHWRITE;
                dp_a <= MHADDR[13:2];
                wcnt <= wait_en ? 2'($urandom_range(0, 2)) : 2'd0;
            end else begin
                dp_v <= 1'b0;
            end
        end
    end

    task automatic fill_expect();
        fill_q.delete();
        for (int i = 0; i < 4096; i++) begin
            fill_q.push_back(12'(i));
            ref_mem[i] = 32'h0;
        end
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        @(negedge HCLK);
        while (!HREADY && n < 20000) begin
            @(negedge HCLK);
            n++;
        end
        if (!HREADY) chk("hready_to", 32'(HREADY), 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!INIT_DONE && n < 40000) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        if (!INIT_DONE) chk("done_to", 32'(INIT_DONE), 32'd1);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic dn);
        HSEL   = 1'b1;
        HADDR  = a;
        HTRANS = 2'b10;
        HWRITE = wr;
        HSIZE  = 3'b010;
        HPROT  = 4'b0011;
        wait_rdy();
        @(posedge HCLK);
        #1;
        HTRANS = 2'b00;
        HWDATA = wr ? wd : 32'h0;
        wait_rdy();
        rd = HRDATA;
        dn = INIT_DONE;
        chk("hresp", 32'(HRESP), 32'd0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                          output logic dn);
        logic [31:0] rd;
        ref_mem[a[13:2]] = d;
        xfer(1'b1, a, d, rd, dn);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic dn);
        logic [31:0] rd;
        logic [31:0] e;
        rd_q.push_back(ref_mem[a[13:2]]);
        xfer(1'b0, a, 32'h0, rd, dn);
        e = rd_q.pop_front();
        chk("rdata", rd, e);
    endtask

    initial begin
        logic dn;
        int   n;
        HSEL     = 1'b1;
        HADDR    = 32'h0;
        HTRANS   = 2'b00;
        HSIZE    = 3'b010;
        HPROT    = 4'b0011;
        HWRITE   = 1'b0;
        HWDATA   = 32'h0;
        INIT_REQ = 1'b0;
        wait_en  = 1'b0;

        repeat (3) @(negedge HCLK);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_done", 32'(INIT_DONE), 32'd0);
        chk("rst_mhaddr", MHADDR, 32'h0);

        HRESETn = 1'b1;
        fill_expect();
        fork
            begin
                int k;
                k = 0;
                while (k < 6000) begin
                    @(posedge HCLK);
                    #1;
                    k++;
                    if (INIT_DONE) break;
                end
                chk("done_lat", 32'(k), 32'd4097);
            end
            begin
                logic d1;
                repeat (10) @(posedge HCLK);
                #1;
                bus_rd(32'h3000_0010, d1);
                chk("rd_stall", 32'(d1), 32'd1);
            end
        join
        chk("fill_left", 32'(fill_q.size()), 32'd0);

        wait_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = 32'h3000_0000 | (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 1) == 1) bus_wr(a, $urandom, dn);
            else bus_rd(a, dn);
        end
        bus_wr(32'h3000_3FFC, 32'h0BAD_CAFE, dn);
        bus_rd(32'h3000_3FFC, dn);

        for (int i = 0; i < 4; i++) begin
            bus_wr(32'h3000_0000 + 32'(i * 4), 32'hA5A5_A5A5, dn);
            bus_wr(32'h3000_3FF0 + 32'(i * 4), 32'hA5A5_A5A5, dn);
        end
        bus_rd(32'h3000_0004, dn);
        bus_rd(32'h3000_3FF8, dn);
        INIT_REQ = 1'b1;
        fill_expect();
        @(posedge HCLK);
        #1;
        INIT_REQ = 1'b0;
        fork
            begin
                logic d2;
                bus_wr(32'h3000_0040, 32'h1122_3344, d2);
                chk("cap_wr_done", 32'(d2), 32'd1);
            end
            begin
                @(posedge HCLK);
                #1;
                chk("done_drop", 32'(INIT_DONE), 32'd0);
            end
        join
        wait_done();
        for (int i = 0; i < 4; i++) begin
            bus_rd(32'h3000_0000 + 32'(i * 4), dn);
            bus_rd(32'h3000_3FF0 + 32'(i * 4), dn);
        end
        bus_rd(32'h3000_0040, dn);
        chk("fill_left2", 32'(fill_q.size()), 32'd0);

        INIT_REQ = 1'b1;
        fill_expect();
        @(posedge HCLK);
        #1;
        INIT_REQ = 1'b0;
        n = 0;
        while (n < 5000) begin
            @(negedge HCLK);
            n++;
            if (MHTRANS == 2'b10 && MHADDR == 32'h190 && !INIT_DONE) break;
        end
        chk("w100_seen", MHADDR, 32'h190);
        HRESETn = 1'b0;
        fill_q.delete();
        #1;
        chk("mid_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("mid_hresp", 32'(HRESP), 32'd0);
        chk("mid_hrdata", HRDATA, 32'h0);
        chk("mid_done", 32'(INIT_DONE), 32'd0);
        chk("mid_mhaddr", MHADDR, 32'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        fill_expect();
        #1;
        chk("rel_mhaddr", MHADDR, 32'h0);
        @(posedge HCLK);
        #1;
        fork
            begin
                logic d3;
                repeat (10) @(posedge HCLK);
                #1;
                bus_wr(32'h3000_0020, 32'hDEAD_BEEF, d3);
            end
            begin
                repeat (50) @(posedge HCLK);
                #1;
                INIT_REQ = 1'b1;
                @(posedge HCLK);
                #1;
                INIT_REQ = 1'b0;
            end
        join
        wait_done();
        bus_rd(32'h3000_0020, dn);
        bus_rd(32'h3000_0024, dn);
        repeat (20) @(posedge HCLK);
        #1;
        chk("req_ignored", 32'(INIT_DONE), 32'd1);
        chk("fill_left3", 32'(fill_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
